// File: rtl/dorodon_input_cond.sv
// Input conditioning for the ladybug core: PS/2 key decode, joystick merge,
// orientation remap and a queued, gap-separated coin pulse shaper.
module dorodon_input_cond #(
    parameter int COIN_PULSE = 400000,
    parameter int COIN_GAP   = 400000,
    parameter int COIN_QMAX  = 3,
    parameter int CNT_W      = 20
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic [1:0]  but_coin_s,
    output logic [1:0]  but_fire_s,
    output logic [1:0]  but_bomb_s,
    output logic [1:0]  but_select_s,
    output logic [1:0]  but_up_s,
    output logic [1:0]  but_down_s,
    output logic [1:0]  but_left_s,
    output logic [1:0]  but_right_s,
    output logic        key_test,
    output logic        coin_busy
);

    localparam int QW = $clog2(COIN_QMAX + 1);
    localparam int NK = 17;

    localparam logic [4:0] K_UP     = 5'd0;
    localparam logic [4:0] K_DOWN   = 5'd1;
    localparam logic [4:0] K_LEFT   = 5'd2;
    localparam logic [4:0] K_RIGHT  = 5'd3;
    localparam logic [4:0] K_FIRE   = 5'd4;
    localparam logic [4:0] K_BOMB   = 5'd5;
    localparam logic [4:0] K_START1 = 5'd6;
    localparam logic [4:0] K_START2 = 5'd7;
    localparam logic [4:0] K_COIN1  = 5'd8;
    localparam logic [4:0] K_COIN2  = 5'd9;
    localparam logic [4:0] K_UP2    = 5'd10;
    localparam logic [4:0] K_DOWN2  = 5'd11;
    localparam logic [4:0] K_LEFT2  = 5'd12;
    localparam logic [4:0] K_RIGHT2 = 5'd13;
    localparam logic [4:0] K_FIRE2  = 5'd14;
    localparam logic [4:0] K_BOMB2  = 5'd15;
    localparam logic [4:0] K_TEST   = 5'd16;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    logic          armed_q;
    logic          hist_q;
    logic [NK-1:0] keys_q, keys_d;
    logic          key_hit;
    logic [4:0]    key_sel;
    logic          key_evt;

    logic [1:0] up_m, down_m, left_m, right_m, fire_m, bomb_m, sel_m;
    logic [1:0] but_up_q, but_down_q, but_left_q, but_right_q;
    logic [1:0] but_fire_q, but_bomb_q, but_select_q;

    logic           coin_req, req_q, coin_edge, coin_deq, coin_low;
    logic [QW-1:0]  queue_q, queue_d;
    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic unused_joy;
    assign unused_joy = ^joy[15:9];

    // Direction keys accept both the plain and the E0-extended code.
    always_comb begin
        key_hit = 1'b1;
        key_sel = K_UP;
        case (ps2_key[8:0])
            9'h075, 9'h175: key_sel = K_UP;
            9'h072, 9'h172: key_sel = K_DOWN;
            9'h06B, 9'h16B: key_sel = K_LEFT;
            9'h074, 9'h174: key_sel = K_RIGHT;
            9'h014:         key_sel = K_FIRE;
            9'h029:         key_sel = K_BOMB;
            9'h005, 9'h016: key_sel = K_START1;
            9'h006, 9'h01E: key_sel = K_START2;
            9'h02E:         key_sel = K_COIN1;
            9'h036:         key_sel = K_COIN2;
            9'h02D:         key_sel = K_UP2;
            9'h02B:         key_sel = K_DOWN2;
            9'h023:         key_sel = K_LEFT2;
            9'h034:         key_sel = K_RIGHT2;
            9'h01C:         key_sel = K_FIRE2;
            9'h01B:         key_sel = K_BOMB2;
            9'h02C:         key_sel = K_TEST;
            default:        key_hit = 1'b0;
        endcase
    end

    assign key_evt = armed_q && (ps2_key[10] != hist_q);

    always_comb begin
        keys_d = keys_q;
        if (key_evt && key_hit) begin
            keys_d[key_sel] = ps2_key[9];
        end
    end

    // armed_q keeps the first post-reset cycle from decoding a stale toggle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            hist_q  <= 1'b0;
            keys_q  <= '0;
        end else begin
            armed_q <= 1'b1;
            hist_q  <= ps2_key[10];
            keys_q  <= keys_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        localparam logic [4:0] KU = (gi == 0) ? K_UP     : K_UP2;
        localparam logic [4:0] KD = (gi == 0) ? K_DOWN   : K_DOWN2;
        localparam logic [4:0] KL = (gi == 0) ? K_LEFT   : K_LEFT2;
        localparam logic [4:0] KR = (gi == 0) ? K_RIGHT  : K_RIGHT2;
        localparam logic [4:0] KF = (gi == 0) ? K_FIRE   : K_FIRE2;
        localparam logic [4:0] KB = (gi == 0) ? K_BOMB   : K_BOMB2;
        localparam logic [4:0] KS = (gi == 0) ? K_START1 : K_START2;

        logic u_src, d_src, l_src, r_src;
        assign u_src = keys_q[KU] | joy[3];
        assign d_src = keys_q[KD] | joy[2];
        assign l_src = keys_q[KL] | joy[1];
        assign r_src = keys_q[KR] | joy[0];

        assign up_m[gi]    = rotate ? l_src : u_src;
        assign down_m[gi]  = rotate ? r_src : d_src;
        assign left_m[gi]  = rotate ? d_src : l_src;
        assign right_m[gi] = rotate ? u_src : r_src;
        assign fire_m[gi]  = keys_q[KF] | joy[4];
        assign bomb_m[gi]  = keys_q[KB] | joy[5];
        assign sel_m[gi]   = keys_q[KS] | joy[6 + gi];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            but_up_q     <= 2'b11;
            but_down_q   <= 2'b11;
            but_left_q   <= 2'b11;
            but_right_q  <= 2'b11;
            but_fire_q   <= 2'b11;
            but_bomb_q   <= 2'b11;
            but_select_q <= 2'b11;
        end else begin
            but_up_q     <= ~up_m;
            but_down_q   <= ~down_m;
            but_left_q   <= ~left_m;
            but_right_q  <= ~right_m;
            but_fire_q   <= ~fire_m;
            but_bomb_q   <= ~bomb_m;
            but_select_q <= ~sel_m;
        end
    end

    assign but_up_s     = but_up_q;
    assign but_down_s   = but_down_q;
    assign but_left_s   = but_left_q;
    assign but_right_s  = but_right_q;
    assign but_fire_s   = but_fire_q;
    assign but_bomb_s   = but_bomb_q;
    assign but_select_s = but_select_q;
    assign key_test     = keys_q[K_TEST];

    assign coin_req  = keys_q[K_COIN1] | keys_q[K_COIN2] | joy[8] | sel_m[0] | sel_m[1];
    assign coin_edge = coin_req & ~req_q;
    assign coin_deq  = (state_q == S_IDLE) && (queue_q != '0);

    // A simultaneous edge and dequeue cancel out, even when the queue is full.
    always_comb begin
        queue_d = queue_q;
        case ({coin_edge, coin_deq})
            2'b10:   queue_d = (queue_q == QW'(COIN_QMAX)) ? queue_q : queue_q + QW'(1);
            2'b01:   queue_d = queue_q - QW'(1);
            default: queue_d = queue_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            queue_q <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            req_q   <= coin_req;
            queue_q <= queue_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (queue_q != '0) begin
                    state_d = S_PULSE;
                    cnt_d   = CNT_W'(COIN_PULSE - 1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(COIN_GAP - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Coin output decodes straight from the state register so reset releases it at once.
    always_comb begin
        coin_low  = (state_q == S_PULSE);
        coin_busy = (state_q != S_IDLE) || (queue_q != '0);
    end

    assign but_coin_s = {1'b1, ~coin_low};

endmodule

// File: tb/tb_dorodon_input_cond.sv
// Bench for dorodon_input_cond: named-key model plus elapsed-time coin model,
// compared every cycle, with literal spot checks on the directed scenarios.
module tb_dorodon_input_cond;

    localparam int P = 10;
    localparam int G = 8;
    localparam int QMAX = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key = 11'h400;
    logic [15:0] joy = 16'h0000;
    logic        rotate = 1'b0;
    logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_select_s;
    logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s;
    logic        key_test, coin_busy;

    dorodon_input_cond #(.COIN_PULSE(P), .COIN_GAP(G), .COIN_QMAX(QMAX), .CNT_W(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy), .rotate(rotate),
        .but_coin_s(but_coin_s), .but_fire_s(but_fire_s), .but_bomb_s(but_bomb_s),
        .but_select_s(but_select_s), .but_up_s(but_up_s), .but_down_s(but_down_s),
        .but_left_s(but_left_s), .but_right_s(but_right_s), .key_test(key_test),
        .coin_busy(coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int failed = 0;

    // Model state: held keys by function name, coin as pending count + elapsed time.
    bit m_armed, m_hist, m_prev_req;
    bit m_held[string];
    int m_pending, m_elapsed;
    logic [1:0] e_up, e_down, e_left, e_right, e_fire, e_bomb, e_sel;

    // Observer of the DUT coin line.
    int  pulse_cnt = 0;
    int  obs_low = 0, obs_high = 0;
    bit  obs_prev_low = 0, obs_seen_end = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string key_func(input logic [8:0] code);
        case (code)
            9'h075, 9'h175: return "up";
            9'h072, 9'h172: return "down";
            9'h06B, 9'h16B: return "left";
            9'h074, 9'h174: return "right";
            9'h014: return "fire";
            9'h029: return "bomb";
            9'h005, 9'h016: return "start1";
            9'h006, 9'h01E: return "start2";
            9'h02E: return "coin1";
            9'h036: return "coin2";
            9'h02D: return "up2";
            9'h02B: return "down2";
            9'h023: return "left2";
            9'h034: return "right2";
            9'h01C: return "fire2";
            9'h01B: return "bomb2";
            9'h02C: return "test";
            default: return "";
        endcase
    endfunction

    function automatic bit held(input string f);
        return m_held.exists(f) ? m_held[f] : 1'b0;
    endfunction

    task automatic model_reset();
        m_held.delete();
        m_armed = 0; m_hist = 0; m_prev_req = 0;
        m_pending = 0; m_elapsed = -1;
        e_up = 2'b11; e_down = 2'b11; e_left = 2'b11; e_right = 2'b11;
        e_fire = 2'b11; e_bomb = 2'b11; e_sel = 2'b11;
        obs_low = 0; obs_high = 0; obs_prev_low = 0; obs_seen_end = 0;
    endtask

    task automatic model_edge(input logic [10:0] k, input logic [15:0] j, input logic rot);
        bit u, d, l, r, req, new_edge, deq;
        string sfx, f;
        for (int p = 0; p < 2; p++) begin
            sfx = (p == 0) ? "" : "2";
            u = held({"up", sfx})    | j[3];
            d = held({"down", sfx})  | j[2];
            l = held({"left", sfx})  | j[1];
            r = held({"right", sfx}) | j[0];
            e_up[p]    = ~(rot ? l : u);
            e_down[p]  = ~(rot ? r : d);
            e_left[p]  = ~(rot ? d : l);
            e_right[p] = ~(rot ? u : r);
            e_fire[p]  = ~(held({"fire", sfx}) | j[4]);
            e_bomb[p]  = ~(held({"bomb", sfx}) | j[5]);
            e_sel[p]   = ~(held($sformatf("start%0d", p + 1)) | j[6 + p]);
        end
        req = held("coin1") | held("coin2") | j[8] | ~e_sel[0] | ~e_sel[1];
        new_edge = req & !m_prev_req;
        m_prev_req = req;
        deq = (m_elapsed < 0) && (m_pending > 0);
        if (m_elapsed >= 0) begin
            m_elapsed++;
            if (m_elapsed == P + G) m_elapsed = -1;
        end else if (deq) begin
            m_elapsed = 0;
        end
        if (new_edge && !deq) m_pending = (m_pending < QMAX) ? m_pending + 1 : QMAX;
        else if (deq && !new_edge) m_pending--;
        if (!m_armed) begin
            m_armed = 1; m_hist = k[10];
        end else if (k[10] != m_hist) begin
            m_hist = k[10];
            f = key_func(k[8:0]);
            if (f != "") m_held[f] = k[9];
        end
    endtask

    task automatic step();
        logic [10:0] k;
        logic [15:0] j;
        logic r;
        k = ps2_key; j = joy; r = rotate;
        @(posedge clk_sys);
        if (reset_n) model_edge(k, j, r);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        step();
    endtask

    always @(negedge clk_sys) begin
        bit exp_low;
        exp_low = (m_elapsed >= 0) && (m_elapsed < P);
        check("coin",   but_coin_s,   {1'b1, ~exp_low});
        check("busy",   coin_busy,    ((m_elapsed >= 0) || (m_pending > 0)) ? 1 : 0);
        check("test",   key_test,     held("test"));
        check("up",     but_up_s,     e_up);
        check("down",   but_down_s,   e_down);
        check("left",   but_left_s,   e_left);
        check("right",  but_right_s,  e_right);
        check("fire",   but_fire_s,   e_fire);
        check("bomb",   but_bomb_s,   e_bomb);
        check("select", but_select_s, e_sel);
        if (!but_coin_s[0]) begin
            if (!obs_prev_low) begin
                pulse_cnt++;
                if (obs_seen_end) check("coin_gap_min", (obs_high >= G) ? 1 : 0, 1);
                obs_low = 0;
            end
            obs_low++;
        end else begin
            if (obs_prev_low) begin
                check("coin_width", obs_low, P);
                obs_seen_end = 1;
                obs_high = 0;
            end
            obs_high++;
        end
        obs_prev_low = !but_coin_s[0];
    end

    initial begin
        int base;
        bit seen;
        model_reset();
        ps2_key = 11'h400;
        #1 reset_n = 0;
        steps(2);
        reset_n = 1;
        step();
        check("rst_fire_lit", but_fire_s, 2'b11);
        check("rst_coin_lit", but_coin_s, 2'b11);

        key(1, 9'h014); step();
        check("fire_press_lit", but_fire_s, 2'b10);
        key(0, 9'h014); step();
        check("fire_rel_lit", but_fire_s, 2'b11);

        key(1, 9'h175); step();
        check("e0_up_lit", but_up_s, 2'b10);
        key(0, 9'h175); step();
        check("e0_uprel_lit", but_up_s, 2'b11);

        rotate = 1;
        key(1, 9'h175); step();
        check("rot_right_lit", but_right_s, 2'b10);
        check("rot_up_lit", but_up_s, 2'b11);
        key(0, 9'h175); step();
        joy = 16'h0001; step();
        check("rot_joyR_down_lit", but_down_s, 2'b00);
        joy = 16'h0000; rotate = 0; step();

        key(1, 9'h02C);
        check("test_lit", key_test, 1);
        key(0, 9'h02C);
        key(1, 9'h0AA); step();
        key(1, 9'h02D); step();
        check("up2_lit", but_up_s, 2'b01);
        key(0, 9'h02D); key(1, 9'h01C); key(1, 9'h034); step();
        key(0, 9'h01C); key(0, 9'h034); steps(2);

        // Single coin from a 5-cycle joy[8] hold.
        base = pulse_cnt;
        joy = 16'h0100; steps(5);
        joy = 16'h0000; steps(P + G + 5);
        check("one_pulse_lit", pulse_cnt - base, 1);
        check("busy_done_lit", coin_busy, 0);

        // Five edges inside the first pulse: 1 running + 3 queued.
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            joy = 16'h0100; step();
            joy = 16'h0000; step();
        end
        steps(4 * (P + G + 1) + 5);
        check("four_pulses_lit", pulse_cnt - base, 4);
        check("busy_after_q_lit", coin_busy, 0);

        // Reset in the middle of a pulse.
        joy = 16'h0100; step();
        joy = 16'h0000;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = !but_coin_s[0];
        end
        check("coin_started", seen, 1);
        steps(3);
        @(negedge clk_sys);
        #1 reset_n = 0;
        model_reset();
        #1;
        check("rst_mid_coin_lit", but_coin_s, 2'b11);
        check("rst_mid_busy_lit", coin_busy, 0);
        steps(2);
        reset_n = 1;
        base = pulse_cnt;
        steps(P + G + 5);
        check("no_pulse_after_rst_lit", pulse_cnt - base, 0);

        // Both start keys held: select both low, one coin only.
        base = pulse_cnt;
        key(1, 9'h016);
        key(1, 9'h01E);
        step();
        check("select_both_lit", but_select_s, 2'b00);
        steps(2 * (P + G + 1) + 5);
        check("select_one_coin_lit", pulse_cnt - base, 1);
        key(0, 9'h016); key(0, 9'h01E);
        steps(P + G + 5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
